// File: rtl/s2p_pkg.sv
// Shared types and sizing helpers for the LSB-first serial-to-parallel frame path.
package s2p_pkg;

    typedef enum logic [0:0] {S_IDLE, S_SHIFT} s2p_state_t;

    // A disabled timeout (0) still needs a 1-bit counter to keep the vector legal.
    function automatic int idleCntWidth(input int timeoutCyc);
        return (timeoutCyc < 1) ? 1 : $clog2(timeoutCyc + 1);
    endfunction

endpackage

// File: rtl/s2p_bit_cnt.sv
// Bit position counter within a word: synchronous clear, enable, terminal flag at BitLen-1.
// Wraps to 0 when enabled at the terminal count, so words can run back-to-back.
module s2p_bit_cnt #(
    parameter int BitLen = 8
) (
    input  logic                      Clk,
    input  logic                      RstB,
    input  logic                      Clr,
    input  logic                      En,
    output logic [$clog2(BitLen)-1:0] Cnt,
    output logic                      Term
);

    localparam int CntW = $clog2(BitLen);
    localparam logic [CntW-1:0] LastCnt = CntW'(BitLen - 1);

    assign Term = (Cnt == LastCnt);

    always_ff @(posedge Clk) begin
        if (!RstB || Clr) begin
            Cnt <= '0;
        end else if (En) begin
            Cnt <= Term ? '0 : Cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Frame sequencer + one-word output buffer for the serial-to-parallel path; word valid the cycle after its last bit.
// Output is valid/ready: a completed word arriving while the held word is unconsumed is dropped and flagged as Overrun.
module s2p_frame_ctrl
    import s2p_pkg::*;
#(
    parameter int BitLen     = 8,
    parameter int TimeoutCyc = 16
) (
    input  logic              Clk,
    input  logic              RstB,
    input  logic              FrameStart,
    input  logic              FrameStop,
    input  logic              SerDataIn,
    input  logic              SerDataEn,
    output logic [BitLen-1:0] ParDataOut,
    output logic              ParValid,
    input  logic              ParReady,
    output logic              Busy,
    output logic              Overrun,
    output logic              TimeoutErr,
    output logic              PartialDrop
);

    localparam int CntW  = $clog2(BitLen);
    localparam int IdleW = idleCntWidth(TimeoutCyc);
    localparam logic [IdleW-1:0] IdleLast = IdleW'((TimeoutCyc > 0) ? TimeoutCyc - 1 : 0);

    s2p_state_t        state;
    logic [BitLen-1:0] sh;
    logic [BitLen-1:0] nextWord;
    logic [IdleW-1:0]  idleCnt;
    logic [CntW-1:0]   bitCnt;
    logic              bitTerm;
    logic              inShift;
    logic              cntNz;
    logic              restart;
    logic              stopHit;
    logic              shiftEn;
    logic              wordDone;
    logic              idleInc;
    logic              timeoutHit;

    // FrameStart outranks FrameStop, which outranks a data bit in the same cycle.
    assign inShift    = (state == S_SHIFT);
    assign cntNz      = (bitCnt != '0);
    assign restart    = inShift && FrameStart;
    assign stopHit    = inShift && !FrameStart && FrameStop;
    assign shiftEn    = inShift && !FrameStart && !FrameStop && SerDataEn;
    assign wordDone   = shiftEn && bitTerm;
    assign nextWord   = {SerDataIn, sh[BitLen-1:1]};
    assign idleInc    = inShift && !FrameStart && !FrameStop && !SerDataEn && cntNz;
    assign timeoutHit = (TimeoutCyc != 0) && idleInc && (idleCnt == IdleLast);
    assign Busy       = inShift;

    s2p_bit_cnt #(.BitLen(BitLen)) u_bit_cnt (
        .Clk  (Clk),
        .RstB (RstB),
        .Clr  (FrameStart || stopHit || timeoutHit),
        .En   (shiftEn),
        .Cnt  (bitCnt),
        .Term (bitTerm)
    );

    always_ff @(posedge Clk) begin
        if (!RstB) begin
            state <= S_IDLE;
        end else if (FrameStart) begin
            state <= S_SHIFT;
        end else if (stopHit || timeoutHit) begin
            state <= S_IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (!RstB || FrameStart) begin
            sh <= '0;
        end else if (shiftEn) begin
            sh <= nextWord;
        end
    end

    // Only counts mid-word silence; the gap between complete words never ages.
    always_ff @(posedge Clk) begin
        if (!RstB || !idleInc || timeoutHit) begin
            idleCnt <= '0;
        end else begin
            idleCnt <= idleCnt + IdleW'(1);
        end
    end

    // The held word is independent of frame state and only dies on reset or acceptance.
    always_ff @(posedge Clk) begin
        if (!RstB) begin
            ParDataOut <= '0;
            ParValid   <= 1'b0;
        end else if (wordDone && (!ParValid || ParReady)) begin
            ParDataOut <= nextWord;
            ParValid   <= 1'b1;
        end else if (ParValid && ParReady) begin
            ParValid   <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!RstB) begin
            Overrun     <= 1'b0;
            TimeoutErr  <= 1'b0;
            PartialDrop <= 1'b0;
        end else begin
            Overrun     <= wordDone && ParValid && !ParReady;
            TimeoutErr  <= timeoutHit;
            PartialDrop <= (restart || stopHit) && cntNz;
        end
    end

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl: directed frames, accepted words checked against a queue of expected words.
module tb_s2p_frame_ctrl;

    logic       Clk = 1'b0;
    logic       RstB = 1'b0;
    logic       FrameStart = 1'b0;
    logic       FrameStop = 1'b0;
    logic       SerDataIn = 1'b0;
    logic       SerDataEn = 1'b0;
    logic [7:0] ParDataOut;
    logic       ParValid;
    logic       ParReady = 1'b0;
    logic       Busy;
    logic       Overrun;
    logic       TimeoutErr;
    logic       PartialDrop;

    int nChecks = 0;
    int nErrors = 0;
    int ovCnt = 0;
    int toCnt = 0;
    int pdCnt = 0;
    int vldCyc = 0;
    logic [7:0] expQ[$];

    s2p_frame_ctrl #(.BitLen(8), .TimeoutCyc(16)) dut (
        .Clk         (Clk),
        .RstB        (RstB),
        .FrameStart  (FrameStart),
        .FrameStop   (FrameStop),
        .SerDataIn   (SerDataIn),
        .SerDataEn   (SerDataEn),
        .ParDataOut  (ParDataOut),
        .ParValid    (ParValid),
        .ParReady    (ParReady),
        .Busy        (Busy),
        .Overrun     (Overrun),
        .TimeoutErr  (TimeoutErr),
        .PartialDrop (PartialDrop)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts pulses and pops the scoreboard on every accepted word.
    always @(negedge Clk) begin
        if (Overrun)     ovCnt++;
        if (TimeoutErr)  toCnt++;
        if (PartialDrop) pdCnt++;
        if (ParValid)    vldCyc++;
        if (RstB && ParValid && ParReady) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("FAIL sb_unexpected: got word 0x%0h, expected none", ParDataOut);
            end else begin
                check("sb_word", {24'd0, ParDataOut}, {24'd0, expQ.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulseStart();
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
    endtask

    task automatic sendBits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            SerDataIn = w[i];
            SerDataEn = 1'b1;
            tick();
        end
        SerDataEn = 1'b0;
        SerDataIn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] w;
        int ovSnap, toSnap, pdSnap, vldSnap;

        tick();
        tick();
        check("rst_valid", {31'd0, ParValid}, 32'd0);
        check("rst_data", {24'd0, ParDataOut}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_pulses", {29'd0, Overrun, TimeoutErr, PartialDrop}, 32'd0);
        RstB = 1'b1;

        // Single word 0xA5 with consumer ready.
        ParReady = 1'b1;
        pulseStart();
        check("t1_busy_open", {31'd0, Busy}, 32'd1);
        expQ.push_back(8'hA5);
        w = 8'hA5;
        sendBits(w, 7);
        check("t1_no_early_valid", {31'd0, ParValid}, 32'd0);
        sendBits({7'd0, w[7]}, 1);
        check("t1_valid", {31'd0, ParValid}, 32'd1);
        check("t1_data", {24'd0, ParDataOut}, 32'hA5);
        tick();
        check("t1_valid_one_cycle", {31'd0, ParValid}, 32'd0);
        check("t1_busy", {31'd0, Busy}, 32'd1);

        // Back-to-back 0x3C, 0xC3 with consumer stalled.
        ParReady = 1'b0;
        expQ.push_back(8'h3C);
        sendBits(8'h3C, 8);
        check("t2_first_valid", {31'd0, ParValid}, 32'd1);
        sendBits(8'hC3, 8);
        check("t2_overrun", {31'd0, Overrun}, 32'd1);
        check("t2_held", {24'd0, ParDataOut}, 32'h3C);
        tick();
        check("t2_overrun_pulse", {31'd0, Overrun}, 32'd0);
        check("t2_held_stable", {24'd0, ParDataOut}, 32'h3C);
        ParReady = 1'b1;
        tick();
        check("t2_valid_drop", {31'd0, ParValid}, 32'd0);
        check("t2_ov_count", ovCnt, 32'd1);
        FrameStop = 1'b1;
        tick();
        FrameStop = 1'b0;
        check("t2_stop_busy", {31'd0, Busy}, 32'd0);
        check("t2_stop_no_drop", pdCnt, 32'd0);

        // Timeout after 3 bits and 16 silent cycles, then a clean 0xFF.
        pulseStart();
        sendBits(8'h05, 3);
        repeat (15) tick();
        check("t3_pre_busy", {31'd0, Busy}, 32'd1);
        check("t3_pre_to", {31'd0, TimeoutErr}, 32'd0);
        tick();
        check("t3_to", {31'd0, TimeoutErr}, 32'd1);
        check("t3_busy", {31'd0, Busy}, 32'd0);
        tick();
        check("t3_to_pulse", {31'd0, TimeoutErr}, 32'd0);
        check("t3_to_count", toCnt, 32'd1);
        check("t3_no_valid", {31'd0, ParValid}, 32'd0);
        pulseStart();
        expQ.push_back(8'hFF);
        sendBits(8'hFF, 8);
        check("t3_ff", {24'd0, ParDataOut}, 32'hFF);
        tick();

        // Restart mid-word, then 0x81.
        sendBits(8'h1F, 5);
        pulseStart();
        check("t4_pdrop", {31'd0, PartialDrop}, 32'd1);
        check("t4_busy", {31'd0, Busy}, 32'd1);
        expQ.push_back(8'h81);
        sendBits(8'h81, 8);
        check("t4_data", {24'd0, ParDataOut}, 32'h81);
        tick();
        check("t4_pd_count", pdCnt, 32'd1);

        // Reset discards a held word and a partial word.
        ParReady = 1'b0;
        sendBits(8'h55, 8);
        check("t5_hold_valid", {31'd0, ParValid}, 32'd1);
        check("t5_hold_data", {24'd0, ParDataOut}, 32'h55);
        sendBits(8'h0F, 4);
        RstB = 1'b0;
        tick();
        RstB = 1'b1;
        check("t5_valid", {31'd0, ParValid}, 32'd0);
        check("t5_data", {24'd0, ParDataOut}, 32'd0);
        check("t5_busy", {31'd0, Busy}, 32'd0);
        check("t5_pulses", {29'd0, Overrun, TimeoutErr, PartialDrop}, 32'd0);
        ParReady = 1'b1;

        // Idle: data strobes and FrameStop must have no effect.
        ovSnap = ovCnt; toSnap = toCnt; pdSnap = pdCnt; vldSnap = vldCyc;
        for (int i = 0; i < 10; i++) begin
            SerDataEn = i[0];
            SerDataIn = 1'b1;
            FrameStop = (i == 4);
            tick();
        end
        SerDataEn = 1'b0;
        FrameStop = 1'b0;
        tick();
        check("t6_busy", {31'd0, Busy}, 32'd0);
        check("t6_valid", {31'd0, ParValid}, 32'd0);
        check("t6_vld_cycles", vldCyc, vldSnap);
        check("t6_pulses", ovCnt + toCnt + pdCnt, ovSnap + toSnap + pdSnap);

        check("sb_drained", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
Frame sequencer and output buffer for the LSB-first serial-to-parallel path. It opens and closes receive frames and gates shifting with a bit-valid strobe. It counts bits to word boundaries and presents each completed word on a valid/ready interface, with overrun, timeout and partial-word error reporting. It sits between the serial pin front-end and the byte consumer, e.g. a register file or FIFO.

Parameters:
BitLen, 8, word width in bits; must be at least 2.
TimeoutCyc, 16, idle cycles allowed mid-word before abort; 0 disables the timeout.

Ports:
Clk  in  1  clock, rising edge.
RstB  in  1  synchronous reset, active-low.
FrameStart  in  1  one-cycle pulse; opens a new frame.
FrameStop  in  1  one-cycle pulse; closes the current frame.
SerDataIn  in  1  serial data bit, LSB first.
SerDataEn  in  1  bit-valid strobe; SerDataIn is sampled when this is 1.
ParDataOut  out  BitLen  completed word.
ParValid  out  1  ParDataOut holds a word not yet consumed.
ParReady  in  1  consumer accepts the word when ParValid & ParReady.
Busy  out  1  frame is open (state SHIFT).
Overrun  out  1  one-cycle pulse; a completed word was dropped.
TimeoutErr  out  1  one-cycle pulse; a partial word was aborted on timeout.
PartialDrop  out  1  one-cycle pulse; a partial word was discarded by FrameStart or FrameStop.

Behaviour:
- Reset, synchronous (RstB=0 at an edge):
  - state IDLE, shift reg 0, bit count 0, idle count 0.
  - ParDataOut=0, ParValid=0, Busy=0, all pulses 0.
  - Any partial word and any held word are discarded.
- States: IDLE, SHIFT.
- IDLE:
  - SerDataEn and FrameStop are ignored.
  - FrameStart -> SHIFT; bit count and shift reg cleared.
- SHIFT:
  - A cycle with SerDataEn=1 shifts: sh <= {SerDataIn, sh[BitLen-1:1]}; bit count +1.
  - Word complete: the SerDataEn cycle where bit count == BitLen-1.
    - Word = {SerDataIn, sh[BitLen-1:1]}.
    - Bit count wraps to 0 and the state stays SHIFT, so words are back-to-back in a frame.
  - FrameStop -> IDLE. If bit count != 0, PartialDrop pulses and the partial word is discarded.
  - FrameStop wins over SerDataEn in the same cycle; that bit is not shifted.
  - FrameStart in SHIFT restarts: count and shift reg cleared, state stays SHIFT. PartialDrop pulses if count != 0.
  - FrameStart wins over FrameStop and SerDataEn in the same cycle.
- Timeout:
  - The idle counter increments on each SHIFT cycle with SerDataEn=0 and bit count != 0. It clears on SerDataEn, on a state change, and whenever bit count == 0. Gaps between words never time out.
  - When the idle count reaches TimeoutCyc: TimeoutErr pulses, the partial word is discarded, state -> IDLE.
  - Counter width is $clog2(TimeoutCyc+1).
- Output register:
  - Latency: ParDataOut/ParValid update on the same edge that samples the last bit, so ParValid is high in the following cycle.
  - On word complete, load when ParValid=0, or when ParValid & ParReady (accept and reload in the same cycle; ParValid stays 1).
  - Otherwise Overrun pulses; the new word is dropped and the held word is unchanged.
  - ParValid & ParReady with no completion -> ParValid <= 0; ParDataOut holds its last value.
  - ParDataOut is stable while ParValid & !ParReady.
  - The output register is independent of frame state: a held word survives FrameStop, FrameStart and timeout.
- Busy = (state == SHIFT). The pulse outputs are registered.

Decomposition:
- Package s2p_pkg holds:
  - typedef enum logic [0:0] {S_IDLE, S_SHIFT} s2p_state_t;
  - localparam function for the counter width.
- Sub-module s2p_bit_cnt: bit counter with clear, enable, terminal flag (count == BitLen-1) and wrap.
- Shift register, idle counter and output register stay in the top.

Test Plan:
- Reset, FrameStart, then bits 1,0,1,0,0,1,0,1 with SerDataEn=1 every cycle and ParReady=1 -> ParDataOut=0xA5; ParValid=1 for exactly one cycle, the cycle after the 8th bit; Busy=1 throughout.
- Frame of words 0x3C then 0xC3, ParReady=0 -> ParDataOut=0x3C held, Overrun pulses one cycle after the 16th bit. ParReady=1 -> ParValid drops next cycle.
- 3 bits, then SerDataEn=0 for 16 cycles (TimeoutCyc=16) -> TimeoutErr pulses once, Busy=0, no ParValid. A later FrameStart plus 0xFF -> ParDataOut=0xFF.
- FrameStart after 5 bits of a word, then bits of 0x81 -> PartialDrop pulses once; ParDataOut=0x81.
- Hold word 0x55 (ParReady=0), shift 4 bits, drive RstB=0 one cycle -> ParValid=0, ParDataOut=0x00, Busy=0, no pulses.
- SerDataEn toggling in IDLE without FrameStart, plus FrameStop in IDLE -> no ParValid, no pulses, Busy=0.
